// File: rtl/execute_muldiv.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over operand magnitudes, with one iteration per clock cycle.
module execute_muldiv #(
  parameter int XLEN     = 64,
  parameter int WORD_OPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW  = $clog2(XLEN);
  localparam int WSH = XLEN - 32;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              word_q, neg_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Operand conditioning at accept time
  logic            word_eff, is_div, a_sop, b_sop, sa, sb, div_zero, div_ovf, special, neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;

  always_comb begin
    word_eff = (WORD_OPS != 0) && (XLEN == 64) && word;
    is_div   = op[2];
    a_sop    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sop    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    if (word_eff) begin
      a_ext = a_sop ? XLEN'($signed(srca[31:0])) : XLEN'(srca[31:0]);
      b_ext = b_sop ? XLEN'($signed(srcb[31:0])) : XLEN'(srcb[31:0]);
      min_val = ~((XLEN'(1) << 31) - XLEN'(1));
    end else begin
      a_ext   = srca;
      b_ext   = srcb;
      min_val = XLEN'(1) << (XLEN - 1);
    end
    sa       = a_sop & a_ext[XLEN-1];
    sb       = b_sop & b_ext[XLEN-1];
    a_mag    = sa ? -a_ext : a_ext;
    b_mag    = sb ? -b_ext : b_ext;
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && b_sop && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || div_ovf;
    neg      = (is_div && op[1]) ? sa : (sa ^ sb);
    if (op[1]) spec_res = div_ovf ? '0 : wfix(word_eff, a_ext);
    else       spec_res = div_zero ? '1 : wfix(word_eff, a_ext);
  end

  // One iteration step and final sign/selection
  logic [XLEN:0]     hi_sum, rem_sh, rem_nx;
  logic              ge;
  logic [2*XLEN-1:0] acc_step, sprod, shifted, hi_sh;
  logic [XLEN-1:0]   mul_val, div_q, div_r, div_val, fin;

  always_comb begin
    hi_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge     = rem_sh >= {1'b0, opnd};
    rem_nx = ge ? rem_sh - {1'b0, opnd} : rem_sh;
    if (op_q[2]) acc_step = {XLEN'(rem_nx), acc[XLEN-2:0], ge};
    else         acc_step = {hi_sum, acc[XLEN-1:1]};
    // A word multiply only shifts 32 times, leaving the product offset by XLEN-32
    sprod   = neg_q ? -acc_step : acc_step;
    shifted = word_q ? (sprod >> WSH) : sprod;
    hi_sh   = shifted >> (word_q ? 32 : XLEN);
    mul_val = (op_q == 3'd0) ? XLEN'(shifted) : XLEN'(hi_sh);
    div_q   = acc_step[XLEN-1:0];
    div_r   = acc_step[2*XLEN-1:XLEN];
    if (op_q[1]) div_val = neg_q ? -div_r : div_r;
    else         div_val = neg_q ? -div_q : div_q;
    fin = wfix(word_q, op_q[2] ? div_val : mul_val);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid && !flush) begin
          op_q   <= op;
          word_q <= word_eff;
          neg_q  <= neg;
          cnt    <= word_eff ? CW'(31) : CW'(XLEN - 1);
          // Divide pre-shifts the dividend so the next bit is always acc[XLEN-1]
          if (is_div) begin
            opnd <= b_mag;
            acc  <= {{XLEN{1'b0}}, (word_eff ? (a_mag << WSH) : a_mag)};
          end else begin
            opnd <= a_mag;
            acc  <= {{XLEN{1'b0}}, b_mag};
          end
          if (special) result <= spec_res;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == '0) result <= fin;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed checks of execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  op = '0;
  logic        word = 1'b0;
  logic [63:0] srca = '0, srcb = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  execute_muldiv #(.XLEN(64), .WORD_OPS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .srca(srca), .srcb(srcb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  a32, b32, r32;
    logic         s_a, s_b;
    s_a = (o == 1) || (o == 2) || (o == 4) || (o == 6);
    s_b = (o == 1) || (o == 4) || (o == 6);
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      r32 = '0;
      case (o)
        3'd0: r32 = a32 * b32;
        3'd4, 3'd6: begin
          if (b32 == 0)                                  r32 = (o == 4) ? 32'hFFFF_FFFF : a32;
          else if (a32 == 32'h8000_0000 && b32 == '1)    r32 = (o == 4) ? a32 : 32'd0;
          else if (o == 4)                               r32 = $signed(a32) / $signed(b32);
          else                                           r32 = $signed(a32) % $signed(b32);
        end
        3'd5, 3'd7: begin
          if (b32 == 0)   r32 = (o == 5) ? 32'hFFFF_FFFF : a32;
          else if (o == 5) r32 = a32 / b32;
          else            r32 = a32 % b32;
        end
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    if (!o[2]) begin
      ea = s_a ? {{64{a[63]}}, a} : {64'd0, a};
      eb = s_b ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      return (o == 0) ? p[63:0] : p[127:64];
    end
    if (b == 0)                                        return o[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (s_a && a == 64'h8000_0000_0000_0000 && b == '1) return o[1] ? 64'd0 : a;
    if (s_a) return o[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic sgn, bz, ovf;
    sgn = (o == 4) || (o == 6);
    if (w) begin
      bz  = (b[31:0] == 0);
      ovf = sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      bz  = (b == 0);
      ovf = sgn && a == 64'h8000_0000_0000_0000 && b == '1;
    end
    if (o[2] && (bz || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic accept(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    check("in_ready_before", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; word = w; srca = a; srcb = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] exp;
    int lat;
    exp = model(o, w, a, b);
    accept(o, w, a, b);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_latency(o, w, a, b)));
    check("result", result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, exp);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("idle_after_handshake", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  o;
    logic        w;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); reset = 1'b1;

    run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5);
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op(3'd5, 1'b0, 64'd7, 64'd0, 0);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    run_op(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 0);
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // flush mid-CALC
    accept(3'd0, 1'b0, 64'd12345, 64'd678);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    watch_no_valid("flush_no_valid", 70);

    // flush together with a request in IDLE
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'd5; srca = 64'd9; srcb = 64'd0;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {63'd0, busy}, 64'd0);

    // reset mid-CALC
    accept(3'd4, 1'b0, 64'd1000, 64'd7);
    repeat (19) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk); reset = 1'b1;
    watch_no_valid("rst_no_valid", 70);
    run_op(3'd4, 1'b0, 64'd1000, 64'd7, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 2) == 0) && !(o inside {3'd1, 3'd2, 3'd3});
      run_op(o, w, pick(), pick(), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the datapath width (legal values 32 and 64).
REQ-002 Parameter WORD_OPS, default 1, SHALL enable the W-variant ops (legal only when XLEN=64).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 op  input  3  operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 word  input  1  W-variant select (MULW/DIVW/DIVUW/REMW/REMUW); SHALL be ignored when WORD_OPS=0.
REQ-009 srca, srcb  input  XLEN  operand a (multiplicand/dividend) and operand b (multiplier/divisor).
REQ-010 flush  input  1  cancel the in-flight operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  final value.
REQ-014 busy  output  1  high whenever the state is not IDLE; used as the pipeline stall source.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-016 in_ready SHALL be high only in IDLE; a request is accepted on a cycle where in_valid && in_ready.
REQ-017 On accept, the unit SHALL register op, word and the conditioned operands, then enter CALC, or enter DONE directly in the special cases of REQ-023/024.
REQ-018 CALC SHALL run N iterations, one per cycle, with N = 32 when word=1 and N = XLEN otherwise; an iteration counter SHALL count N-1 down to 0.
REQ-019 Multiply SHALL be radix-2 shift-add over magnitudes with a 2*N-bit product register; the sign SHALL be applied after the last iteration.
REQ-020 Divide SHALL be restoring division over magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Result selection: MUL = product low N bits; MULH/MULHSU/MULHU = product high N bits with the signedness (a,b) of (s,s), (s,u), (u,u).
REQ-022 Word ops SHALL use srca[31:0] and srcb[31:0], sign- or zero-extended per op; the result SHALL be sign-extended from bit 31 to XLEN.
REQ-023 Divide by zero: quotient = all ones (in N bits), remainder = dividend; the unit SHALL go directly to DONE with no CALC cycles.
REQ-024 Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend, remainder = 0; the unit SHALL go directly to DONE.
REQ-025 Latency: with accept in cycle T, out_valid SHALL be high from cycle T+N+1 (normal ops) or T+1 (special cases).
REQ-026 In DONE, out_valid SHALL be high and result SHALL hold stable until out_ready; on out_valid && out_ready the unit SHALL return to IDLE.
REQ-027 Back-to-back operation: the earliest next accept SHALL be the cycle after the result handshake, since in_ready is high in IDLE only.
REQ-028 flush in any state SHALL force IDLE on the next edge and drop the result; flush SHALL take priority over the handshake in the same cycle.
REQ-029 flush and in_valid in the same IDLE cycle: the request SHALL NOT be accepted.
REQ-030 Outputs SHALL be registered or derived from state only, with no combinational path from srca/srcb to result.

Reset
REQ-031 When reset is low the unit SHALL, asynchronously: state=IDLE, counter=0, out_valid=0, busy=0, result=0, in_ready=1 once reset is released.
REQ-032 Reset asserted mid-CALC SHALL abandon the operation; no out_valid SHALL follow after release.

Verification
REQ-033 XLEN=64: MUL a=0xFFFFFFFFFFFFFFFF, b=2 -> out_valid at T+65, result=0xFFFFFFFFFFFFFFFE; MULHU of the same operands -> result=1.
REQ-034 DIV a=-7, b=2 -> quotient -3; REM -> remainder -1; DIVU a=7, b=0 -> out_valid at T+1, result=0xFFFFFFFFFFFFFFFF.
REQ-035 DIV a=0x8000000000000000, b=-1 -> result=0x8000000000000000 at T+1; REM -> 0.
REQ-036 DIVW a=0x00000000_80000000, b=0xFFFFFFFF -> result=0xFFFFFFFF80000000 at T+1; MULW 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE at T+33.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; flush at CALC cycle 10 -> IDLE next cycle and no out_valid.
REQ-038 Drive reset low at CALC cycle 20 -> busy=0 and out_valid=0 immediately; a new request after release completes correctly.
